rtc_time_core: RTL
==================

Name: rtc_time_core

Overview:
Parametrised real-time-clock core that succeeds the fixed 10 MHz 12-hour clock.
- Keeps time internally as a 24-hour hour:minute:second count.
- Presents the time in 12-hour or 24-hour format, selected at runtime.
- Supports synchronous time load with range checking, a minute-resolution alarm, and a fast-tick test mode.
- Sits between the top-level pin wrapper (which supplies settings and muxes the outputs onto pins) and the system clock.

Parameters:
CLK_FREQ_HZ, 10_000_000, input clock frequency; the divider wraps at CLK_FREQ_HZ-1 (must be >= 2).
DIV_W, 24, divider counter width; must satisfy 2**DIV_W >= CLK_FREQ_HZ.
ALARM_EN, 1, 1 = alarm logic present; 0 = alarm_pulse tied 0 and alarm inputs ignored.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  count enable; 0 freezes divider and time
mode_24h  in  1  output format: 0 = 12-hour, 1 = 24-hour
fast_mode  in  1  1 = one second tick per enabled clock cycle (test)
set_valid  in  1  single-cycle load strobe
set_hour  in  5  load hour, always 24-hour encoding 0..23
set_min  in  6  load minute 0..59
set_sec  in  6  load second 0..59
alarm_on  in  1  alarm arm
alarm_hour  in  5  alarm hour, 24-hour encoding 0..23
alarm_min  in  6  alarm minute 0..59
hour  out  5  displayed hour (1..12 or 0..23)
minute  out  6  current minute
second  out  6  current second
pm  out  1  1 when internal hour >= 12, in both modes
tick_1hz  out  1  one-cycle pulse, high the cycle the new time is visible
set_err  out  1  one-cycle pulse: last set_valid rejected
alarm_pulse  out  1  one-cycle pulse on alarm match

Behaviour:
Reset (rst_n = 0, asynchronous):
- divider = 0, hr24 = 0, min = 0, sec = 0.
- All pulses = 0.
- Outputs therefore show 12:00:00 with pm = 0 in 12-hour mode, or 00:00:00 in 24-hour mode.

Divider:
- Counts up while ena = 1.
- sec_tick is asserted when divider == CLK_FREQ_HZ-1; on that edge the divider returns to 0.
- fast_mode = 1: sec_tick = ena on every cycle; the divider holds at 0.
- ena = 0: divider, time and all pulses are frozen/0.

Time update on sec_tick edge:
- sec increments; 59 -> 0 and carries into min.
- min 59 -> 0 carries into hr24.
- hr24 23 -> 0.
- 23:59:59 -> 00:00:00 in a single edge.

Outputs:
- minute, second and pm are a combinational function of the state registers; hour is a combinational function of the state registers and mode_24h. No extra latency.
- 12-hour mode: hour = hr24 mod 12, with 0 mapped to 12.
- 24-hour mode: hour = hr24.
- Changing mode_24h changes hour in the same cycle; it never alters state.

tick_1hz:
- Registered; asserts in the cycle after the sec_tick edge, coincident with the updated time.
- In fast_mode with ena held high it stays high continuously.

Set:
- set_valid is sampled every cycle regardless of ena.
- Valid when set_hour <= 23, set_min <= 59 and set_sec <= 59.
- Valid load: hr24/min/sec load on that edge, the divider clears to 0, and no tick_1hz or alarm_pulse is produced for that edge.
- Invalid load: state is unchanged and set_err pulses high for the next cycle.
- set_valid has priority over a coincident sec_tick; that tick is discarded.

Alarm (ALARM_EN = 1):
- alarm_pulse is registered and coincident with tick_1hz.
- It fires when a sec_tick update produces hr24 == alarm_hour, min == alarm_min and sec == 0, with alarm_on = 1.
- It is never produced by a set load.
- Out-of-range alarm values never match.

Reset mid-operation: asynchronous clear to the reset state, overriding any pending set or pulse.

Test Plan:
Settings: CLK_FREQ_HZ = 4, DIV_W = 3.
1. Release reset, mode_24h = 0, ena = 1, 12 cycles -> hour = 12, pm = 0, second = 3; tick_1hz high once every 4 cycles.
2. Set 23:59:59, run one second -> 12:00:00 with pm = 0 (12-hour); with mode_24h = 1, 00:00:00. Set 11:59:59 -> after a tick, hour = 12, pm = 1.
3. set_valid with hour = 24 -> set_err high for one cycle, time unchanged. set_min = 60 -> same result.
4. set_valid asserted on the same cycle the divider = 3 -> loaded value shown, no tick_1hz; next tick arrives 4 cycles later.
5. Alarm 07:30, alarm_on = 1, set 07:29:58, fast_mode = 1 -> alarm_pulse exactly once, coincident with 07:30:00. Repeat with alarm_on = 0 -> no pulse.
6. ena = 0 for 10 cycles mid-count -> time and divider frozen. Assert rst_n low mid-count -> immediate 12:00:00 AM and all pulses 0.

Source files
------------

// File: rtl/rtc_time_core_if.sv
// Settings and display bundle between the pin wrapper (master) and the RTC core (slave).
interface rtc_time_core_if;
  logic       ena;
  logic       mode_24h;
  logic       fast_mode;
  logic       set_valid;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       alarm_on;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       pm;
  logic       tick_1hz;
  logic       set_err;
  logic       alarm_pulse;

  modport master (
    output ena, mode_24h, fast_mode, set_valid, set_hour, set_min, set_sec,
           alarm_on, alarm_hour, alarm_min,
    input  hour, minute, second, pm, tick_1hz, set_err, alarm_pulse
  );

  modport slave (
    input  ena, mode_24h, fast_mode, set_valid, set_hour, set_min, set_sec,
           alarm_on, alarm_hour, alarm_min,
    output hour, minute, second, pm, tick_1hz, set_err, alarm_pulse
  );
endinterface

// File: rtl/rtc_time_core.sv
// Real-time-clock core: 24-hour internal time, 12/24-hour display, checked load,
// minute-resolution alarm and a one-tick-per-cycle test mode.
module rtc_time_core #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int DIV_W       = 24,
  parameter int ALARM_EN    = 1
) (
  input logic          clk,
  input logic          rst_n,
  rtc_time_core_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_MAX       = DIV_W'(CLK_FREQ_HZ - 1);
  localparam logic             ALARM_PRESENT = (ALARM_EN != 0);

  function automatic logic set_in_range(input logic [4:0] h, input logic [5:0] m,
                                        input logic [5:0] s);
    return (h <= 5'd23) && (m <= 6'd59) && (s <= 6'd59);
  endfunction

  logic [DIV_W-1:0] div_r;
  logic [4:0]       hr_r;
  logic [5:0]       min_r;
  logic [5:0]       sec_r;
  logic             tick_r;
  logic             err_r;
  logic             alarm_r;

  logic             sec_tick_s;
  logic             set_ok_s;
  logic             alarm_hit_s;
  logic [4:0]       hr_nxt_s;
  logic [5:0]       min_nxt_s;
  logic [5:0]       sec_nxt_s;
  logic [4:0]       hour_s;

  assign sec_tick_s = bus.ena && (bus.fast_mode || (div_r == DIV_MAX));
  assign set_ok_s   = set_in_range(bus.set_hour, bus.set_min, bus.set_sec);

  // Next time value for a one-second advance, with full rollover at 23:59:59.
  always_comb begin
    hr_nxt_s  = hr_r;
    min_nxt_s = min_r;
    sec_nxt_s = sec_r + 6'd1;
    if (sec_r == 6'd59) begin
      sec_nxt_s = 6'd0;
      if (min_r == 6'd59) begin
        min_nxt_s = 6'd0;
        if (hr_r == 5'd23) begin
          hr_nxt_s = 5'd0;
        end else begin
          hr_nxt_s = hr_r + 5'd1;
        end
      end else begin
        min_nxt_s = min_r + 6'd1;
      end
    end else begin
      sec_nxt_s = sec_r + 6'd1;
    end
  end

  // Out-of-range alarm settings can never equal a reachable hr/min, so no explicit check.
  assign alarm_hit_s = ALARM_PRESENT && bus.alarm_on && (sec_nxt_s == 6'd0) &&
                       (hr_nxt_s == bus.alarm_hour) && (min_nxt_s == bus.alarm_min);

  // Divider and time state; any load strobe swallows a coincident second tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
      hr_r  <= 5'd0;
      min_r <= 6'd0;
      sec_r <= 6'd0;
    end else if (bus.set_valid) begin
      if (set_ok_s) begin
        div_r <= '0;
        hr_r  <= bus.set_hour;
        min_r <= bus.set_min;
        sec_r <= bus.set_sec;
      end
    end else if (sec_tick_s) begin
      div_r <= '0;
      hr_r  <= hr_nxt_s;
      min_r <= min_nxt_s;
      sec_r <= sec_nxt_s;
    end else if (bus.ena) begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Registered pulses, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r  <= 1'b0;
      err_r   <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      tick_r  <= sec_tick_s && !bus.set_valid;
      err_r   <= bus.set_valid && !set_ok_s;
      alarm_r <= sec_tick_s && !bus.set_valid && alarm_hit_s;
    end
  end

  // Display hour: 12-hour mode maps 0 to 12 and 13..23 to 1..11.
  always_comb begin
    hour_s = hr_r;
    if (bus.mode_24h) begin
      hour_s = hr_r;
    end else if (hr_r == 5'd0) begin
      hour_s = 5'd12;
    end else if (hr_r > 5'd12) begin
      hour_s = hr_r - 5'd12;
    end else begin
      hour_s = hr_r;
    end
  end

  assign bus.hour        = hour_s;
  assign bus.minute      = min_r;
  assign bus.second      = sec_r;
  assign bus.pm          = (hr_r >= 5'd12);
  assign bus.tick_1hz    = tick_r;
  assign bus.set_err     = err_r;
  assign bus.alarm_pulse = alarm_r;

endmodule
